unidade_controle_multiciclo: RTL
================================

Name: unidade_controle_multiciclo

Overview:
- Multi-cycle MIPS control FSM. Sequences a shared-ALU, single-memory datapath: fetch, decode, execute, memory, writeback.
- Supported instructions: LW, SW, R-type, BEQ, J.
- Sits beside the datapath and drives its register enables and mux selects.
- Waits on a memory-ready handshake so that memory can take multiple cycles.

Parameters:
- OPCODE_LW, 6'b100011, load word opcode
- OPCODE_SW, 6'b101011, store word opcode
- OPCODE_R, 6'b000000, R-type opcode
- OPCODE_BEQ, 6'b000100, branch-equal opcode
- OPCODE_J, 6'b000010, jump opcode

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; returns FSM to FETCH
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward
- memReady  in  1  memory completes current read/write this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero (BEQ)
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- memToReg  out  1  writeback select: 0=ALUOut, 1=MDR
- regDst  out  1  destination select: 0=rt, 1=rd
- regWrite  out  1  register file write enable
- aluSrcA  out  1  ALU A select: 0=PC, 1=reg A
- aluSrcB  out  2  ALU B select: 00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded
- pcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instrDone  out  1  one-cycle pulse on the final cycle of each instruction
- illegalOp  out  1  sticky; set on unsupported opcode, cleared only by reset

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BEQ_EXEC, J_EXEC. Encoding is free; one state register.
- Reset (asynchronous): state=FETCH, illegalOp=0. While reset is held, all outputs are 0.
- Outputs are combinational from state. memReady qualifies only the signals noted below.
- Any signal not listed for a state is 0.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE:
  - aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Next state: LW/SW->MEM_ADDR, R->R_EXEC, BEQ->BEQ_EXEC, J->J_EXEC.
  - Any other opcode: set illegalOp, pulse instrDone, go to FETCH (instruction treated as NOP).
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Next state: LW->MEM_RD, SW->MEM_WR.
- MEM_RD: memRead=1, iorD=1. Stay until memReady=1, then go to MEM_WB.
- MEM_WB: regDst=0, memToReg=1, regWrite=1, instrDone=1. Next state: FETCH.
- MEM_WR:
  - memWrite=1, iorD=1; memWrite stays asserted through wait cycles.
  - When memReady=1: instrDone=1, go to FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next state: R_WB.
- R_WB: regDst=1, memToReg=0, regWrite=1, instrDone=1. Next state: FETCH.
- BEQ_EXEC: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Next state: FETCH.
- J_EXEC: pcWrite=1, pcSource=10, instrDone=1. Next state: FETCH.
- Latency with memReady held high, cycles from FETCH entry to instrDone inclusive: LW 5, SW 4, R 4, BEQ 3, J 3, illegal 2.
- Each memory wait cycle adds exactly one cycle.
- memRead and memWrite are never asserted together.
- regWrite and pcWrite are never asserted in the same cycle.
- Reset asserted mid-instruction, including during a memory wait: FSM returns to FETCH immediately and all outputs drop to 0 asynchronously.
- No partial write completes after reset deasserts.
- opcode is sampled only in DECODE and MEM_ADDR. The datapath holds IR stable after FETCH.

Test Plan:
- Reset, then deassert with memReady=1 and opcode=000000 -> FETCH (irWrite=1, pcWrite=1, aluSrcB=01), DECODE, R_EXEC (aluOp=10), R_WB (regDst=1, regWrite=1, instrDone=1); 4 cycles, back in FETCH.
- LW (100011) with memReady low for 2 cycles in FETCH and 3 cycles in MEM_RD -> latency 5+2+3=10 cycles; irWrite and pcWrite pulse only on the memReady cycle; MEM_WB has memToReg=1, regWrite=1.
- SW (101011) with memReady=0 for 1 cycle in MEM_WR -> memWrite=1, iorD=1 for 2 consecutive cycles; regWrite never 1; instrDone on the second cycle.
- BEQ (000100), then J (000010) back-to-back -> BEQ_EXEC has pcWriteCond=1, aluOp=01, pcSource=01 (3 cycles); J_EXEC has pcWrite=1, pcSource=10 (3 cycles); instrDone pulses once per instruction.
- Opcode 001000 (unsupported) -> illegalOp rises in DECODE and stays 1 through a following valid R-type; 2-cycle return to FETCH; regWrite, memWrite and pcWrite stay 0 after FETCH.
- Assert reset during the second wait cycle of MEM_RD -> memRead drops to 0 the same cycle without a clock edge; after release the FSM is in FETCH and illegalOp=0.

Source files
------------

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface unidade_controle_multiciclo_if;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       memToReg;
  logic       regDst;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic       instrDone;
  logic       illegalOp;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp
  );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle MIPS control FSM (LW/SW/R/BEQ/J) for a shared-ALU, single-memory datapath.
//  state    | meaning
//  FETCH    | read instruction at PC, PC+4 -> PC on memReady
//  DECODE   | branch target -> ALUOut, dispatch on opcode
//  MEM_ADDR | base + imm -> ALUOut
//  MEM_RD   | load read, waits on memReady
//  MEM_WB   | MDR -> rt
//  MEM_WR   | store write, waits on memReady
//  R_EXEC   | A op B
//  R_WB     | ALUOut -> rd
//  BEQ_EXEC | A - B, PC <- ALUOut if zero
//  J_EXEC   | PC <- jump target
module unidade_controle_multiciclo (
  input  logic                          clock,
  input  logic                          reset,
  unidade_controle_multiciclo_if.master ctl
);
  localparam logic [5:0] OPCODE_LW  = 6'b100011;
  localparam logic [5:0] OPCODE_SW  = 6'b101011;
  localparam logic [5:0] OPCODE_R   = 6'b000000;
  localparam logic [5:0] OPCODE_BEQ = 6'b000100;
  localparam logic [5:0] OPCODE_J   = 6'b000010;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BEQ_EXEC = 4'd8;
  localparam logic [3:0] S_J_EXEC   = 4'd9;

  logic [3:0] state_q, state_d;
  logic       illegal_op_q, illegal_op_d;

  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, decode_bad;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_comb begin
    state_d       = state_q;
    illegal_op_d  = illegal_op_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    decode_bad    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ctl.memReady;
        pc_write  = ctl.memReady;
        if (ctl.memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (ctl.opcode)
          OPCODE_LW, OPCODE_SW: state_d = S_MEM_ADDR;
          OPCODE_R:             state_d = S_R_EXEC;
          OPCODE_BEQ:           state_d = S_BEQ_EXEC;
          OPCODE_J:             state_d = S_J_EXEC;
          default: begin
            // Unsupported opcode retires as a NOP and flags the sticky error.
            decode_bad   = 1'b1;
            illegal_op_d = 1'b1;
            instr_done   = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (ctl.opcode == OPCODE_LW)      state_d = S_MEM_RD;
        else if (ctl.opcode == OPCODE_SW) state_d = S_MEM_WR;
        else                              state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (ctl.memReady) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        if (ctl.memReady) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ_EXEC: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_J_EXEC: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Reset masks every output asynchronously so nothing is driven while held.
  assign ctl.pcWrite     = ~reset & pc_write;
  assign ctl.pcWriteCond = ~reset & pc_write_cond;
  assign ctl.iorD        = ~reset & ior_d;
  assign ctl.memRead     = ~reset & mem_read;
  assign ctl.memWrite    = ~reset & mem_write;
  assign ctl.irWrite     = ~reset & ir_write;
  assign ctl.memToReg    = ~reset & mem_to_reg;
  assign ctl.regDst      = ~reset & reg_dst;
  assign ctl.regWrite    = ~reset & reg_write;
  assign ctl.aluSrcA     = ~reset & alu_src_a;
  assign ctl.aluSrcB     = reset ? 2'b00 : alu_src_b;
  assign ctl.aluOp       = reset ? 2'b00 : alu_op;
  assign ctl.pcSource    = reset ? 2'b00 : pc_source;
  assign ctl.instrDone   = ~reset & instr_done;
  assign ctl.illegalOp   = ~reset & (illegal_op_q | decode_bad);
endmodule
